// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register: valid/ready handshake, synchronous flush, saturating stall and
// flush counters. Define PIPE_STAGE_SKID_EN to add a 1-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] CLEAR_VAL = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              main_load;

  // Main register takes a new beat when empty or when its current beat leaves this cycle.
  assign main_load = ~out_valid_q | out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  assign in_ready = ~skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      out_data_d   = CLEAR_VAL;
      skid_valid_d = 1'b0;
    end else if (main_load) begin
      // A held skid beat always goes first; in_ready is low while it is held.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_valid;
        if (in_valid) begin
          out_data_d = in_data;
        end
      end
    end else if (in_valid && in_ready) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= CLEAR_VAL;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  assign in_ready = main_load;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_data_d  = CLEAR_VAL;
    end else if (main_load) begin
      out_valid_d = in_valid;
      if (in_valid) begin
        out_data_d = in_data;
      end
    end
  end
`endif

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_q && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= CLEAR_VAL;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-boundary register for the MIPS core. It is the general successor to the fixed 32-bit IF/ID register and is reusable at IF/ID, ID/EX, EX/MEM and MEM/WB. It replaces the bare stall/clear pair with a valid/ready handshake, a synchronous flush that inserts a bubble, saturating stall and flush counters, and an optional skid buffer. The skid buffer registers the upstream ready so that the stall path is cut.

## Interface
- DATA_W, 64, width of the payload (for example instruction plus PC+4 at IF/ID).
- CLEAR_VAL, {DATA_W{1'b0}}, value loaded into out_data on reset and flush (a NOP encoding).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- flush  in  1  synchronous kill of all held beats (branch mispredict, exception).
- out_valid  out  1  out_data holds a live beat.
- out_ready  in  1  downstream accepts the beat this cycle.
- out_data  out  DATA_W  registered payload.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.
- flush_cnt  out  CNT_W  saturating count of cycles with flush=1.

## Operation
- Handshakes: an input transfer happens when in_valid & in_ready; an output transfer happens when out_valid & out_ready.
- Main register: holds out_valid and out_data. It loads when it is empty or when its beat is leaving this cycle.
- Priority, highest first: rst_n low, then flush, then normal handshake.
- Flush:
  - Next cycle, out_valid=0, skid empty and out_data=CLEAR_VAL.
  - An input transfer in the same cycle is accepted and discarded.
  - An output transfer in the same cycle still completes downstream.
- Payload is never modified. out_data is stable while out_valid=1 and out_ready=0.
- When the main register is empty or idle, out_data holds its last value (or CLEAR_VAL after reset or flush). Consumers must qualify it with out_valid.
- stall_cnt increments on every cycle with out_valid & ~out_ready & ~flush.
- flush_cnt increments on every flush cycle.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- Beats are delivered in order, with no duplication or loss except on flush.

## Timing
- Reset values: out_valid=0, out_data=CLEAR_VAL, stall_cnt=0, flush_cnt=0. The skid buffer is empty. in_ready=1 once rst_n has deasserted.
- Latency: a beat accepted in cycle N is presented on out_valid/out_data in cycle N+1.
- Throughput: one beat per cycle while out_ready=1.
- Without skid: in_ready = ~out_valid | out_ready, which is combinational from out_ready.
- With skid: in_ready = ~skid_valid, driven from a flop.
  - A beat accepted while the main register is full and not draining goes into the skid buffer. in_ready drops the next cycle.
  - When the main register drains, the skid beat moves into it the next cycle. The skid entry frees and in_ready rises again.
  - If both the main register and the skid buffer drain in a chain, order is preserved: the skid beat always precedes the new beat.
- Reset asserted mid-transfer clears everything immediately and asynchronously. Beats that were in flight are lost.

## Configuration
- PIPE_STAGE_SKID_EN defined: a 1-entry skid buffer is instantiated and in_ready is registered (no out_ready to in_ready combinational path). Storage is 2 beats; full throughput is kept under back-pressure.
- PIPE_STAGE_SKID_EN undefined: no skid buffer, and in_ready is combinational as given above. Storage is 1 beat. Behaviour is equivalent to a classic stall register.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 and in_data=64'hDEAD. Required: out_valid=0, out_data=0 and both counters 0. After release, out_valid=1 one cycle after the first accepted beat.
- Streaming: out_ready=1 with beats 1..8 sent back-to-back. Required: out_data shows 1..8 in consecutive cycles, each one cycle after its input, and stall_cnt=0.
- Back-pressure: with out_valid=1 and beat A held, drive out_ready=0 for 3 cycles while in_valid=1 with beat B.
  - Required: out_data=A stable and stall_cnt=3.
  - Without skid: in_ready=0 throughout.
  - With skid: B is accepted once and in_ready=0 from the next cycle on. After out_ready=1, A then B are delivered.
- Flush: assert flush for 1 cycle while the main register and skid hold beats and in_valid=1. Required: next cycle out_valid=0, out_data=CLEAR_VAL, flush_cnt=1, and no pre-flush beat ever appears at the output.
- Counter saturation: use CNT_W=4 and hold out_ready=0 for 20 cycles with out_valid=1. Required: stall_cnt=15 and it stays there.
- Asynchronous reset mid-stall: pulse rst_n low between clock edges while back-pressured. Required: out_valid=0 immediately with no clock edge, and the skid buffer is empty.
